alu_display_mux: RTL and testbench

//   Parametrised signed ALU with a multiplexed 7-segment readout. Registers a, b and op.

---
 rtl/alu_display_mux.sv | 185 ++++++++++++++++++
 tb/tb_alu_display_mux.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_display_mux.sv
// Signed ALU with registered operands, sequential double-dabble conversion and a
// multiplexed common-anode 7-segment readout (sign + decimal magnitude).
//
// state  | meaning
// IDLE   | display current; waiting for a new result/op class or pending start
// LOAD   | snapshot result, sign and magnitude; clear BCD
// SHIFT  | WIDTH add-3/shift steps of double dabble
// COMMIT | write the formatted digits into the display buffer in one cycle
module alu_display_mux #(
   parameter int WIDTH       = 6,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk_100MHz,
   input  logic              rst,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [2:0]        op,
   output logic              err,
   output logic              busy,
   output logic [DIGITS-1:0] anodes,
   output logic [7:0]        cathodes
);
   localparam int NB = 5;  // enough BCD nibbles for a 16-bit magnitude
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

   logic [WIDTH-1:0] a_r, b_r, res_r, alu_res, snap_res, mag;
   logic [2:0]       op_r;
   logic             alu_err, alu_inv, inv_r, snap_inv, snap_neg, pending;
   state_t           state;
   logic [4:0]       sh_cnt;
   logic [4*NB-1:0]  bcd, bcd_adj;
   logic [4*(NB+DIGITS)-1:0] bcd_pad;
   logic [7:0]       disp [DIGITS];
   logic [7:0]       fmt  [DIGITS];
   logic [CW-1:0]    ref_cnt;
   logic [IW-1:0]    idx;

   function automatic logic [4*NB-1:0] dd_adjust(input logic [4*NB-1:0] v);
      for (int i = 0; i < NB; i++)
         if (v[4*i +: 4] >= 4'd5) v[4*i +: 4] = v[4*i +: 4] + 4'd3;
      return v;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      alu_inv = 1'b0;
      case (op_r)
         3'b000: begin
            alu_res = a_r + b_r;
            alu_err = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (alu_res[WIDTH-1] != a_r[WIDTH-1]);
         end
         3'b001: begin
            alu_res = a_r - b_r;
            alu_err = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (alu_res[WIDTH-1] != a_r[WIDTH-1]);
         end
         3'b010: alu_res = a_r & b_r;
         3'b011: alu_res = a_r | b_r;
         3'b100: alu_res = a_r ^ b_r;
         3'b101: begin
            alu_res = '0 - a_r;
            alu_err = (a_r == {1'b1, {(WIDTH-1){1'b0}}});
         end
         default: begin
            alu_inv = 1'b1;
            alu_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= '0;
         res_r <= '0;
         inv_r <= 1'b0;
         err   <= 1'b0;
      end else begin
         a_r   <= a;
         b_r   <= b;
         op_r  <= op;
         res_r <= alu_res;
         inv_r <= alu_inv;
         err   <= alu_err;
      end
   end

   assign bcd_adj = dd_adjust(bcd);
   assign bcd_pad = {{(4*DIGITS){1'b0}}, bcd};

   // Digits above the most significant nonzero nibble are blanked; the sign sits just left of it.
   always_comb begin
      int msd;
      msd = 0;
      for (int i = 0; i < NB; i++)
         if (bcd[4*i +: 4] != 4'd0) msd = i;
      for (int d = 0; d < DIGITS; d++) begin
         fmt[d] = SEG_BLANK;
         if (snap_inv || (msd + 1 > DIGITS - 1)) fmt[d] = SEG_DASH;
         else if (d <= msd)                      fmt[d] = seg7(bcd_pad[4*d +: 4]);
         else if (snap_neg && d == msd + 1)      fmt[d] = SEG_DASH;
      end
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pending  <= 1'b1;
         snap_res <= '0;
         snap_inv <= 1'b0;
         snap_neg <= 1'b0;
         mag      <= '0;
         bcd      <= '0;
         sh_cnt   <= '0;
         for (int d = 0; d < DIGITS; d++) disp[d] <= SEG_BLANK;
      end else begin
         case (state)
            IDLE: if (pending || res_r != snap_res || inv_r != snap_inv) state <= LOAD;
            LOAD: begin
               pending  <= 1'b0;
               snap_res <= res_r;
               snap_inv <= inv_r;
               snap_neg <= res_r[WIDTH-1];
               mag      <= res_r[WIDTH-1] ? ('0 - res_r) : res_r;
               bcd      <= '0;
               sh_cnt   <= 5'(WIDTH - 1);
               state    <= SHIFT;
            end
            SHIFT: begin
               {bcd, mag} <= {bcd_adj[4*NB-2:0], mag, 1'b0};
               if (sh_cnt == 5'd0) state <= COMMIT;
               else                sh_cnt <= sh_cnt - 5'd1;
            end
            COMMIT: begin
               for (int d = 0; d < DIGITS; d++) disp[d] <= fmt[d];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         ref_cnt  <= '0;
         idx      <= '0;
         anodes   <= '1;
         cathodes <= SEG_BLANK;
      end else begin
         anodes   <= ~(DIGITS'(1) << idx);
         cathodes <= disp[idx];
         if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            ref_cnt <= ref_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_alu_display_mux.sv
// Directed bench: stimulus pushes hand-computed display images, a monitor scans the
// multiplexed outputs after every conversion and compares against the queue head.
module tb_alu_display_mux;
   localparam int W  = 6;
   localparam int D  = 4;
   localparam int RD = 4;

   logic          clk_100MHz = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [2:0]    op = 3'b000;
   logic          err, busy;
   logic [D-1:0]  anodes;
   logic [7:0]    cathodes;

   int total = 0;
   int bad   = 0;
   bit strict = 1'b1;
   logic [31:0] exp_q [$];

   alu_display_mux #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD)) dut (
      .clk_100MHz(clk_100MHz), .rst(rst), .a(a), .b(b), .op(op),
      .err(err), .busy(busy), .anodes(anodes), .cathodes(cathodes));

   always #5 clk_100MHz = ~clk_100MHz;

   function automatic logic [7:0] seg_of(input byte c);
      case (c)
         "0": return 8'hC0;  "1": return 8'hF9;  "2": return 8'hA4;  "3": return 8'hB0;
         "4": return 8'h99;  "5": return 8'h92;  "6": return 8'h82;  "7": return 8'hF8;
         "8": return 8'h80;  "9": return 8'h90;  "-": return 8'hBF;
         default: return 8'hFF;
      endcase
   endfunction

   // Leftmost character of the string is the leftmost digit (digit D-1).
   function automatic logic [31:0] disp_of(input string s);
      logic [31:0] r;
      for (int i = 0; i < D; i++) r[8*i +: 8] = seg_of(s[D-1-i]);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic apply(input int o, input int x, input int y, input string s, input logic e);
      logic [31:0] ox, xx, yx;
      ox = o; xx = x; yx = y;
      @(negedge clk_100MHz);
      op = ox[2:0]; a = xx[W-1:0]; b = yx[W-1:0];
      exp_q.push_back(disp_of(s));
      @(posedge clk_100MHz);
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      check({"err ", s}, {31'b0, err}, {31'b0, e});
      repeat (45) @(negedge clk_100MHz);
      check({"pending ", s}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin : monitor
      logic prev_busy, ok;
      logic [31:0] got, e;
      logic [D-1:0] mask;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk_100MHz);
         if (rst) prev_busy = 1'b0;
         else if (prev_busy && !busy) begin
            ok = 1'b1; mask = '0; got = '1;
            @(negedge clk_100MHz);
            for (int t = 0; t < D*RD; t++) begin
               @(negedge clk_100MHz);
               if (rst || busy) begin ok = 1'b0; break; end
               total++;
               if ($countones(~anodes) != 1) begin
                  bad++;
                  $display("FAIL anode_onehot got=%b required=one low bit", anodes);
               end
               for (int i = 0; i < D; i++)
                  if (!anodes[i]) begin got[8*i +: 8] = cathodes; mask[i] = 1'b1; end
            end
            if (ok && mask == '1) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL display_unexpected got=%h required=nothing queued", got);
               end else begin
                  if (!strict)
                     while (exp_q.size() > 1 && exp_q[0] != got) void'(exp_q.pop_front());
                  e = exp_q.pop_front();
                  check("display", got, e);
               end
            end
            prev_busy = busy;
         end else prev_busy = busy;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      // reset state
      repeat (3) @(negedge clk_100MHz);
      check("rst_anodes", 32'(anodes), 32'hF);
      check("rst_cathodes", 32'(cathodes), 32'hFF);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      exp_q.push_back(disp_of("   0"));
      rst = 1'b0;

      // refresh rotation: each anode low for RD cycles, in order
      n = 0;
      while (anodes != 4'b1101 && n < 50) begin @(negedge clk_100MHz); n++; end
      check("anode_slot1", 32'(anodes), 32'hD);
      repeat (2) @(negedge clk_100MHz);
      check("anode_mid1", 32'(anodes), 32'hD);
      repeat (4) @(negedge clk_100MHz);
      check("anode_mid2", 32'(anodes), 32'hB);
      repeat (4) @(negedge clk_100MHz);
      check("anode_mid3", 32'(anodes), 32'h7);
      repeat (4) @(negedge clk_100MHz);
      check("anode_mid0", 32'(anodes), 32'hE);
      repeat (30) @(negedge clk_100MHz);
      check("pending reset", 32'(exp_q.size()), 32'd0);

      // reset pulse in the middle of a conversion
      op = 3'b000; a = 6'd9; b = 6'd10;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk_100MHz); n++; end
      check("busy_start", {31'b0, busy}, 32'd1);
      repeat (3) @(negedge clk_100MHz);
      #2 rst = 1'b1; a = '0; b = '0;
      #1;
      check("pulse_anodes", 32'(anodes), 32'hF);
      check("pulse_cathodes", 32'(cathodes), 32'hFF);
      check("pulse_err", {31'b0, err}, 32'd0);
      check("pulse_busy", {31'b0, busy}, 32'd0);
      exp_q.push_back(disp_of("   0"));
      @(negedge clk_100MHz);
      rst = 1'b0;
      repeat (45) @(negedge clk_100MHz);
      check("pending pulse", 32'(exp_q.size()), 32'd0);

      apply(0,   9,  10, "  19", 1'b0);
      apply(0,   9, -11, "  -2", 1'b0);
      apply(1,  -4,   9, " -13", 1'b0);
      apply(0,  16,  23, " -25", 1'b1);
      apply(5, -32,   0, " -32", 1'b1);
      apply(6,   0,   0, "----", 1'b1);
      apply(0,   5,  -5, "   0", 1'b0);
      apply(2,  -1,  12, "  12", 1'b0);
      apply(3, -32,   1, " -31", 1'b0);
      apply(4,   7,  -1, "  -8", 1'b0);
      apply(1, -32,   1, "  31", 1'b1);
      apply(7,   3,   3, "----", 1'b1);
      apply(5,   5,   0, "  -5", 1'b0);

      // operand churn during conversion: only complete pairs may ever be displayed
      strict = 1'b0;
      @(negedge clk_100MHz);
      op = 3'b000; a = 6'd3; b = 6'd1; exp_q.push_back(disp_of("   4"));
      for (int k = 2; k <= 4; k++) begin
         repeat (3) @(negedge clk_100MHz);
         b = W'(k);
         exp_q.push_back(disp_of(k == 2 ? "   5" : (k == 3 ? "   6" : "   7")));
      end
      repeat (60) @(negedge clk_100MHz);
      n = 0;
      while (busy && n < 40) begin @(negedge clk_100MHz); n++; end
      check("churn_busy", {31'b0, busy}, 32'd0);
      check("churn_err", {31'b0, err}, 32'd0);
      check("pending churn", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
